// File: rtl/pwm_dt_pkg.sv
// pwm_dt_pkg: shared types and defaults for the dead-time PWM splitter.
package pwm_dt_pkg;

  localparam int DT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/pwm_dt_cnt.sv
// pwm_dt_cnt: loadable down-counter with a zero flag; saturates at 0.
module pwm_dt_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins over decrement; decrement stops at zero so the count never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: splits a timer PWM into complementary high/low gate drives
// with programmable dead time. Optional fault latch under `PWM_DT_FAULT_EN.
module pwm_deadtime
  import pwm_dt_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            pwm_i,
  input  logic            oen_i,
  input  logic            en_i,
  input  logic [DT_W-1:0] dt_rise_i,
  input  logic [DT_W-1:0] dt_fall_i,
  input  logic            fault_i,
  input  logic            fault_clr_i,
  output logic            pwm_hi_o,
  output logic            pwm_lo_o,
  output logic            fault_o,
  output logic [2:0]      state_o
);

  state_e          state, state_n;
  logic            target, target_n;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [DT_W-1:0] cnt_val;
  logic            run;

  // driver is only allowed to run while both the block and the pad are enabled
  assign run = en_i & oen_i;

  pwm_dt_cnt #(.W(DT_W)) u_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // state and target registers; async reset drops outputs immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= ST_OFF;
      target <= 1'b0;
    end else begin
      state  <= state_n;
      target <= target_n;
    end
  end

  // next-state and counter control; dt inputs only matter on a load
  always_comb begin
    state_n  = state;
    target_n = target;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = pwm_i ? dt_rise_i : dt_fall_i;
    case (state)
      ST_OFF: begin
        if (run) begin
          state_n  = ST_DEAD;
          target_n = pwm_i;
          cnt_load = 1'b1;
        end
      end
      ST_DEAD: begin
        if (!run) begin
          state_n = ST_OFF;
        end else if (pwm_i != target) begin
          // input flipped mid-dead-time: restart with the new side's delay
          target_n = pwm_i;
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          state_n = target ? ST_HI : ST_LO;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HI: begin
        if (!run) begin
          state_n = ST_OFF;
        end else if (!pwm_i) begin
          state_n  = ST_DEAD;
          target_n = 1'b0;
          cnt_load = 1'b1;
        end
      end
      ST_LO: begin
        if (!run) begin
          state_n = ST_OFF;
        end else if (pwm_i) begin
          state_n  = ST_DEAD;
          target_n = 1'b1;
          cnt_load = 1'b1;
        end
      end
`ifdef PWM_DT_FAULT_EN
      ST_FAULT: begin
        // clear is honoured only once the fault source has gone away
        if (fault_clr_i && !fault_i) state_n = ST_OFF;
      end
`endif
      default: state_n = ST_OFF;
    endcase
`ifdef PWM_DT_FAULT_EN
    if (fault_i) begin
      state_n  = ST_FAULT;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
`endif
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    pwm_hi_o = (state == ST_HI);
    pwm_lo_o = (state == ST_LO);
    state_o  = state;
`ifdef PWM_DT_FAULT_EN
    fault_o  = (state == ST_FAULT);
`else
    fault_o  = 1'b0;
`endif
  end

`ifndef PWM_DT_FAULT_EN
  // fault inputs have no function in this build
  logic unused_fault;
  assign unused_fault = &{1'b0, fault_i, fault_clr_i};
`endif

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed table of vectors plus hand-written corner sequences.
module tb_pwm_deadtime;

  localparam logic [2:0] S_OFF = 3'd0, S_DEAD = 3'd1, S_HI = 3'd2, S_LO = 3'd3, S_FLT = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm = 1'b0, oen = 1'b0, en = 1'b0, flt = 1'b0, clr = 1'b0;
  logic [7:0] dtr = '0, dtf = '0;
  logic       hi, lo, fo;
  logic [2:0] st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.DT_W(8)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .pwm_i       (pwm),
    .oen_i       (oen),
    .en_i        (en),
    .dt_rise_i   (dtr),
    .dt_fall_i   (dtf),
    .fault_i     (flt),
    .fault_clr_i (clr),
    .pwm_hi_o    (hi),
    .pwm_lo_o    (lo),
    .fault_o     (fo),
    .state_o     (st)
  );

  typedef struct {
    logic       rst, en, oen, pwm;
    logic [7:0] dtr, dtf;
    logic [2:0] st;
    logic       hi, lo;
    string      nm;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, e, o, p, input int dr, df,
                     input logic [2:0] s, input logic h, l, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.oen = o; v.pwm = p;
    v.dtr = 8'(dr); v.dtf = 8'(df);
    v.st = s; v.hi = h; v.lo = l; v.nm = nm;
    tv.push_back(v);
  endtask

  task automatic check(input string nm, input logic [2:0] es, input logic eh, el, ef);
    n_vec++;
    if ({st, hi, lo, fo} !== {es, eh, el, ef}) begin
      n_err++;
      $display("FAIL %s: got state=%0d hi=%b lo=%b fault=%b, want state=%0d hi=%b lo=%b fault=%b",
               nm, st, hi, lo, fo, es, eh, el, ef);
    end
  endtask

  task automatic drive(input logic e, o, p, input int dr, df, input logic f, c);
    @(negedge clk);
    en = e; oen = o; pwm = p; dtr = 8'(dr); dtf = 8'(df); flt = f; clr = c;
  endtask

  // the two gate drives must never overlap
  always @(negedge clk) begin
    if (hi && lo) begin
      n_err++;
      $display("FAIL overlap: got hi=%b lo=%b, want never both 1", hi, lo);
    end
  end

  initial begin
    int dead;
    //   rst en oen pwm dtr dtf   state   hi lo
    add(1, 1, 1, 1, 3, 0, S_OFF,  0, 0, "reset");
    add(0, 1, 1, 1, 3, 0, S_DEAD, 0, 0, "start_dead0");
    add(0, 1, 1, 1, 3, 0, S_DEAD, 0, 0, "start_dead1");
    add(0, 1, 1, 1, 3, 0, S_DEAD, 0, 0, "start_dead2");
    add(0, 1, 1, 1, 3, 0, S_DEAD, 0, 0, "start_dead3");
    add(0, 1, 1, 1, 3, 0, S_HI,   1, 0, "start_hi");
    add(0, 1, 1, 1, 3, 0, S_HI,   1, 0, "hold_hi");
    add(0, 1, 1, 0, 3, 0, S_DEAD, 0, 0, "fall_dt0_dead");
    add(0, 1, 1, 0, 3, 0, S_LO,   0, 1, "fall_dt0_lo");
    add(0, 1, 1, 0, 3, 0, S_LO,   0, 1, "hold_lo");
    add(0, 1, 1, 1, 5, 0, S_DEAD, 0, 0, "rise_dt5");
    add(0, 1, 1, 0, 5, 2, S_DEAD, 0, 0, "retarget_dead0");
    add(0, 1, 1, 0, 5, 7, S_DEAD, 0, 0, "retarget_dead1");
    add(0, 1, 1, 0, 5, 7, S_DEAD, 0, 0, "retarget_dead2");
    add(0, 1, 1, 0, 5, 7, S_LO,   0, 1, "retarget_lo");
    add(0, 1, 1, 1, 0, 0, S_DEAD, 0, 0, "rise_dt0_dead");
    add(0, 1, 1, 1, 0, 0, S_HI,   1, 0, "rise_dt0_hi");
    add(0, 1, 0, 1, 0, 0, S_OFF,  0, 0, "oen_off");
    add(0, 1, 0, 1, 0, 0, S_OFF,  0, 0, "oen_off_hold");
    add(0, 1, 1, 1, 2, 0, S_DEAD, 0, 0, "oen_on_dead0");
    add(0, 1, 1, 1, 2, 0, S_DEAD, 0, 0, "oen_on_dead1");
    add(0, 1, 1, 1, 2, 0, S_DEAD, 0, 0, "oen_on_dead2");
    add(0, 1, 1, 1, 2, 0, S_HI,   1, 0, "oen_on_hi");
    add(0, 1, 1, 0, 2, 4, S_DEAD, 0, 0, "fall_dt4");
    add(0, 0, 1, 0, 2, 4, S_OFF,  0, 0, "en_off_in_dead");
    add(0, 1, 1, 0, 2, 1, S_DEAD, 0, 0, "en_on_dead0");
    add(0, 1, 1, 0, 2, 1, S_DEAD, 0, 0, "en_on_dead1");
    add(0, 1, 1, 0, 2, 1, S_LO,   0, 1, "en_on_lo");

    foreach (tv[i]) begin
      @(negedge clk);
      rst = tv[i].rst; en = tv[i].en; oen = tv[i].oen; pwm = tv[i].pwm;
      dtr = tv[i].dtr; dtf = tv[i].dtf; flt = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      check(tv[i].nm, tv[i].st, tv[i].hi, tv[i].lo, 1'b0);
    end

    // maximum dead time: dt=255 gives 256 dead cycles; dt changes mid-count are ignored
    drive(1, 1, 1, 255, 0, 0, 0);
    dead = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      dtr = 8'd0;
      if (hi) break;
      if (st == S_DEAD) dead++;
    end
    n_vec++;
    if (dead != 256 || !hi) begin
      n_err++;
      $display("FAIL max_dead: got %0d dead cycles hi=%b, want 256 dead cycles then hi=1", dead, hi);
    end

`ifdef PWM_DT_FAULT_EN
    drive(1, 1, 1, 0, 0, 1, 0); @(posedge clk); #1;
    check("fault_enter", S_FLT, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1, 1); @(posedge clk); #1;
    check("fault_clr_held", S_FLT, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 0, 1); @(posedge clk); #1;
    check("fault_clr_off", S_OFF, 0, 0, 0);
`else
    drive(1, 1, 1, 0, 0, 1, 0); @(posedge clk); #1;
    check("fault_ignored", S_HI, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 1, 1); @(posedge clk); #1;
    check("fault_clr_ignored", S_HI, 1, 0, 0);
`endif
    drive(1, 1, 1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_hi", S_HI, 1, 0, 0);

    // asynchronous reset mid-cycle: outputs must drop before the next edge
    #2 rst = 1'b1;
    #1 check("async_rst", S_OFF, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_rst_dead", S_DEAD, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
